// File: rtl/moore_vending_fsm.sv
// Moore coin-accepting vending controller: accumulates 5/10/25 kurus coins and strobes theProduct for one cycle per sale.
// Optional change output guarded by `CHANGE_RETURN_EN.
module moore_vending_fsm #(
   parameter int PRICE = 25
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fiveKurus,
   input  logic       tenKurus,
   input  logic       twentyFiveKurus,
`ifdef CHANGE_RETURN_EN
   output logic [6:0] change,
`endif
   output logic       theProduct
);

   localparam int CW = $clog2(PRICE + 25) + 1;

   typedef enum logic {ACCUM, DISPENSE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] credit, credit_nxt;
   logic [CW-1:0] coin_val, sum;
`ifdef CHANGE_RETURN_EN
   logic [6:0]    change_nxt;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= ACCUM;
         credit <= '0;
`ifdef CHANGE_RETURN_EN
         change <= '0;
`endif
      end else begin
         state  <= state_nxt;
         credit <= credit_nxt;
`ifdef CHANGE_RETURN_EN
         change <= change_nxt;
`endif
      end
   end

   // One coin per cycle; lower-priority coins in the same cycle are dropped.
   always_comb begin
      coin_val = '0;
      if (twentyFiveKurus)  coin_val = CW'(25);
      else if (tenKurus)    coin_val = CW'(10);
      else if (fiveKurus)   coin_val = CW'(5);
   end

   assign sum = credit + coin_val;

   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
`ifdef CHANGE_RETURN_EN
      change_nxt = '0;
`endif
      case (state)
         ACCUM: begin
            if (sum >= CW'(PRICE)) begin
               state_nxt  = DISPENSE;
               credit_nxt = '0;
`ifdef CHANGE_RETURN_EN
               change_nxt = 7'(sum - CW'(PRICE));
`endif
            end else begin
               credit_nxt = sum;
            end
         end
         DISPENSE: begin
            // Coins seen during the dispense cycle are lost.
            state_nxt  = ACCUM;
            credit_nxt = '0;
         end
         default: begin
            state_nxt  = ACCUM;
            credit_nxt = '0;
         end
      endcase
   end

   assign theProduct = (state == DISPENSE);

endmodule

// File: tb/tb_moore_vending_fsm.sv
// Directed bench for moore_vending_fsm: integer credit model checked every cycle plus literal pins.
module tb_moore_vending_fsm;

   localparam int PRICE = 25;

   logic clock = 1'b0;
   logic reset;
   logic fiveKurus = 1'b0, tenKurus = 1'b0, twentyFiveKurus = 1'b0;
   logic theProduct;
`ifdef CHANGE_RETURN_EN
   logic [6:0] change;
`endif

   int errors = 0;
   int checks = 0;
   bit run_cmp = 1'b0;
   int strobes = 0;

   int m_credit = 0;
   bit m_disp = 1'b0;
   int m_change = 0;

   moore_vending_fsm #(.PRICE(PRICE)) dut (
      .clock(clock),
      .reset(reset),
      .fiveKurus(fiveKurus),
      .tenKurus(tenKurus),
      .twentyFiveKurus(twentyFiveKurus),
`ifdef CHANGE_RETURN_EN
      .change(change),
`endif
      .theProduct(theProduct)
   );

   always #5 clock = ~clock;

   // Sale model in plain kurus arithmetic.
   always @(posedge clock or negedge reset) begin
      int v, s;
      if (!reset) begin
         m_disp   <= 1'b0;
         m_credit <= 0;
         m_change <= 0;
      end else if (m_disp) begin
         m_disp   <= 1'b0;
         m_credit <= 0;
         m_change <= 0;
      end else begin
         v = twentyFiveKurus ? 25 : tenKurus ? 10 : fiveKurus ? 5 : 0;
         s = m_credit + v;
         if (s >= PRICE) begin
            m_disp   <= 1'b1;
            m_change <= s - PRICE;
            m_credit <= 0;
         end else begin
            m_credit <= s;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (run_cmp) begin
         chk("model_product", int'(theProduct), int'(m_disp));
`ifdef CHANGE_RETURN_EN
         chk("model_change", int'(change), m_disp ? m_change : 0);
`endif
      end
   end

   always @(posedge clock) if (theProduct === 1'b1) strobes++;

   task automatic step(input logic f, input logic t, input logic q);
      @(negedge clock);
      fiveKurus = f; tenKurus = t; twentyFiveKurus = q;
   endtask

   // Let the edge sampling the last driven coin happen, then look just after it.
   task automatic after_edge();
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b0;
      // Reset hold with dimes arriving.
      for (int i = 0; i < 9; i++) begin
         step(1'b0, (i % 2) == 0, 1'b0);
         after_edge();
         chk("reset_hold_product", int'(theProduct), 0);
      end
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      run_cmp = 1'b1;

      // After release credit starts at 0: a 10 then 10 must not sell.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      after_edge();
      chk("post_reset_20_no_sale", int'(theProduct), 0);
      step(1'b1, 1'b0, 1'b0);
      after_edge();
      chk("post_reset_25_sale", int'(theProduct), 1);
      step(1'b0, 1'b0, 1'b0);
      after_edge();
      chk("post_reset_strobe_drop", int'(theProduct), 0);

      // Exact price: 10,5,5,5.
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      after_edge();
      chk("exact_credit20_no_sale", int'(theProduct), 0);
      step(1'b1, 1'b0, 1'b0);
      after_edge();
      chk("exact_sale", int'(theProduct), 1);
`ifdef CHANGE_RETURN_EN
      chk("exact_change", int'(change), 0);
`endif
      step(1'b0, 1'b0, 1'b0);
      after_edge();
      chk("exact_one_cycle", int'(theProduct), 0);

      // Overpay: 10,5,5,10 -> change 5.
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      after_edge();
      chk("overpay_sale", int'(theProduct), 1);
`ifdef CHANGE_RETURN_EN
      chk("overpay_change", int'(change), 5);
`endif
      step(1'b0, 1'b0, 1'b0);
      after_edge();
      chk("overpay_drop", int'(theProduct), 0);
`ifdef CHANGE_RETURN_EN
      chk("overpay_change_clear", int'(change), 0);
`endif
      // Credit must be 0 now: a lone 20 worth of coins must not sell.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      after_edge();
      chk("overpay_credit_zero", int'(theProduct), 0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Continuous dimes for 6 cycles: exactly one strobe, credit 20 left.
      @(negedge clock);
      strobes = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      after_edge();
      chk("dimes_one_strobe", strobes, 1);
      step(1'b1, 1'b0, 1'b0);
      after_edge();
      chk("dimes_leftover_20_plus_5", int'(theProduct), 1);
`ifdef CHANGE_RETURN_EN
      chk("dimes_leftover_change", int'(change), 0);
`endif
      step(1'b0, 1'b0, 1'b0);
      after_edge();

      // Simultaneous coins count as 25 only.
      step(1'b1, 1'b1, 1'b1);
      after_edge();
      chk("simul_sale", int'(theProduct), 1);
`ifdef CHANGE_RETURN_EN
      chk("simul_change", int'(change), 0);
`endif
      step(1'b0, 1'b0, 1'b0);
      after_edge();

      // Async reset during DISPENSE.
      step(1'b0, 1'b0, 1'b1);
      after_edge();
      chk("async_pre_sale", int'(theProduct), 1);
      fiveKurus = 1'b0; tenKurus = 1'b0; twentyFiveKurus = 1'b0;
      #2 reset = 1'b0;
      #1 chk("async_drop_immediate", int'(theProduct), 0);
      @(negedge clock);
      reset = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      after_edge();
      chk("async_10_no_sale", int'(theProduct), 0);
      step(1'b0, 1'b0, 1'b1);
      after_edge();
      chk("async_25_sale", int'(theProduct), 1);
`ifdef CHANGE_RETURN_EN
      chk("async_25_change", int'(change), 10);
`endif
      step(1'b0, 1'b0, 1'b0);
      after_edge();
      chk("final_idle", int'(theProduct), 0);

      @(negedge clock);
      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
